// File: rtl/i2s_to_wb_rx_pkg.sv
// i2s_to_wb_rx_pkg: shared state encodings and constants for the I2S bridge paths
package i2s_to_wb_rx_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } rx_state_e;
  localparam int SYNC_DEPTH = 2;
  localparam logic WS_LEFT = 1'b0;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/i2s_to_wb_rx_if.sv
// i2s_to_wb_rx_if: valid/ready sample-pair channel from the receiver to the Wishbone side
interface i2s_to_wb_rx_if #(
  parameter int SAMPLE_WIDTH = 32
) ();
  logic                    rx_valid;
  logic                    rx_ready;
  logic [SAMPLE_WIDTH-1:0] rx_left_data;
  logic [SAMPLE_WIDTH-1:0] rx_right_data;
  modport master (output rx_valid, rx_left_data, rx_right_data, input rx_ready);
  modport slave (input rx_valid, rx_left_data, rx_right_data, output rx_ready);
endinterface

// File: rtl/i2s_to_wb_sync.sv
// i2s_to_wb_sync: equal-depth synchronizer for sck/ws/sd plus sck rising-edge detect
module i2s_to_wb_sync
  import i2s_to_wb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_o,
  output logic sd_o
);
  logic [2:0] stg_q [SYNC_DEPTH];
  logic       sck_dly_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q     <= '{default: '0};
      sck_dly_q <= 1'b0;
    end else begin
      stg_q[0] <= {sd_i, ws_i, sck_i};
      for (int i = 1; i < SYNC_DEPTH; i++) stg_q[i] <= stg_q[i-1];
      sck_dly_q <= stg_q[SYNC_DEPTH-1][0];
    end
  end
  assign {sd_o, ws_o} = stg_q[SYNC_DEPTH-1][2:1];
  assign sck_rise_o   = stg_q[SYNC_DEPTH-1][0] & ~sck_dly_q;
endmodule

// File: rtl/i2s_to_wb_rx.sv
// i2s_to_wb_rx: oversampling I2S receiver delivering MSB-justified left/right pairs on valid/ready
module i2s_to_wb_rx
  import i2s_to_wb_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                   i2s_clk_i,
  input  logic                   i2s_rst_i,
  input  logic                   i2s_enable,
  input  logic                   i2s_sck_i,
  input  logic                   i2s_ws_i,
  input  logic                   i2s_sd_i,
  input  logic                   ovf_clr,
  i2s_to_wb_rx_if.master         rx,
  output logic                   rx_ws_edge,
  output logic                   rx_overflow,
  output logic [FRAME_CNT_W-1:0] rx_frame_cnt
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [SAMPLE_WIDTH-1:0] TOP_BIT = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

  rx_state_e               state_q, state_d;
  logic                    sck_rise, ws_s, sd_s, ws_chg, run, pair, load;
  logic                    ws_prev_q, ws_prev_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] word, shf_q, shf_d, hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                    valid_q, valid_d, ovf_q, ovf_d, wse_q, wse_d;
  logic [FRAME_CNT_W-1:0]  cnt_q, cnt_d;

  i2s_to_wb_sync u_sync (
    .clk        (i2s_clk_i),
    .rst        (i2s_rst_i),
    .sck_i      (i2s_sck_i),
    .ws_i       (i2s_ws_i),
    .sd_i       (i2s_sd_i),
    .sck_rise_o (sck_rise),
    .ws_o       (ws_s),
    .sd_o       (sd_s)
  );

  assign ws_chg = sck_rise & (ws_s != ws_prev_q);

  always_ff @(posedge i2s_clk_i) state_q <= i2s_rst_i ? IDLE : state_d;

  always_comb begin
    state_d = !i2s_enable ? IDLE :
              (state_q == IDLE) ? SYNC :
              (state_q == SYNC && ws_chg && ws_s == WS_LEFT) ? RUN : state_q;
  end

  // The bit sampled on a WS change is the LSB of the word just ending, so it is merged before completion.
  always_comb begin
    run       = i2s_enable & (state_q == RUN);
    word      = sd_s ? (shf_q | (TOP_BIT >> bit_cnt_q)) : shf_q;
    pair      = run & ws_chg & (ws_prev_q != WS_LEFT);
    load      = pair & (~valid_q | rx.rx_ready);
    ws_prev_d = sck_rise ? ws_s : ws_prev_q;
    bit_cnt_d = (!run || ws_chg) ? '0 :
                (!sck_rise || bit_cnt_q == CW'(SAMPLE_WIDTH)) ? bit_cnt_q : bit_cnt_q + 1'b1;
    shf_d     = (!run || ws_chg) ? '0 : (sck_rise ? word : shf_q);
    hold_d    = !i2s_enable ? '0 : (run && ws_chg && ws_prev_q == WS_LEFT) ? word : hold_q;
    left_d    = load ? hold_q : left_q;
    right_d   = load ? word : right_q;
    valid_d   = i2s_enable & (load | (valid_q & ~rx.rx_ready));
    ovf_d     = (pair & valid_q & ~rx.rx_ready) | (ovf_q & ~ovf_clr);
    cnt_d     = load ? cnt_q + 1'b1 : cnt_q;
    wse_d     = ws_chg & i2s_enable & (state_q != IDLE);
  end

  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i) begin
      ws_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      shf_q     <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      wse_q     <= 1'b0;
    end else begin
      ws_prev_q <= ws_prev_d;
      bit_cnt_q <= bit_cnt_d;
      shf_q     <= shf_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      wse_q     <= wse_d;
    end
  end

  assign rx.rx_valid      = valid_q;
  assign rx.rx_left_data  = left_q;
  assign rx.rx_right_data = right_q;
  assign rx_ws_edge       = wse_q;
  assign rx_overflow      = ovf_q;
  assign rx_frame_cnt     = cnt_q;
endmodule
